// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback complete in one clock.
// Instruction memory, register file, ALU and data memory are all internal; only the PC is reset.

// Combinational instruction ROM, word-indexed; contents are loaded from outside.
module rv32i_inst_mem #(
  parameter int unsigned Words = 256,
  parameter int unsigned Aw    = $clog2(Words)
) (
  input  logic [Aw-1:0] addr_i,
  output logic [31:0]   instr_o
);
  logic [31:0] mem [0:Words-1];

  assign instr_o = mem[addr_i];
endmodule

// 32 x 32 register file: two async read ports, one write port; x0 is hard-wired to zero.
module rv32i_reg_file (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);
  logic [31:0] reg_mem [0:31];

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : reg_mem[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : reg_mem[rs2_addr_i];

  // Write port; reads see the old value in the same cycle.
  always_ff @(posedge clk_i) begin
    if (we_i && (rd_addr_i != 5'd0)) begin
      reg_mem[rd_addr_i] <= rd_data_i;
    end
  end
endmodule

// ALU; op_i = {funct7[5], funct3} for arithmetic, add for address/AUIPC use.
module rv32i_alu (
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);
  logic [31:0] sra_res;

  // Arithmetic shift kept separate so signedness is not lost in a mixed expression.
  always_comb begin
    sra_res = $signed(a_i) >>> b_i[4:0];
  end

  // Result select by funct3, with funct7[5] choosing SUB and SRA.
  always_comb begin
    result_o = 32'd0;
    case (op_i[2:0])
      3'b000:  result_o = op_i[3] ? (a_i - b_i) : (a_i + b_i);
      3'b001:  result_o = a_i << b_i[4:0];
      3'b010:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      3'b011:  result_o = {31'd0, (a_i < b_i)};
      3'b100:  result_o = a_i ^ b_i;
      3'b101:  result_o = op_i[3] ? sra_res : (a_i >> b_i[4:0]);
      3'b110:  result_o = a_i | b_i;
      default: result_o = a_i & b_i;
    endcase
  end
endmodule

module rv32i_single_cycle_core #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned ImemAw = $clog2(IMEM_WORDS);
  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;
  localparam logic [1:0] WbImmU = 2'd3;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  wb_sel;
  logic        wb_en, rf_we;
  logic [31:0] rd_data;
  logic        is_store, dmem_we;
  logic [3:0]  byte_en;
  logic [31:0] store_data;
  logic [31:0] dmem_rdata, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        br_taken;
  logic [31:0] jalr_tgt;
  logic [DmemAw-1:0] dmem_idx;

  logic [31:0] dmem [0:DMEM_WORDS-1];

  rv32i_inst_mem #(
    .Words (IMEM_WORDS)
  ) inst_mem_i (
    .addr_i  (pc_q[ImemAw+1:2]),
    .instr_o (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  rv32i_reg_file reg_file_i (
    .clk_i      (clk),
    .we_i       (rf_we),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rd_addr_i  (rd),
    .rd_data_i  (rd_data),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  rv32i_alu alu_i (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result)
  );

  // Decode: ALU operands/op, writeback source and enable per opcode.
  always_comb begin
    alu_op   = 4'b0000;
    alu_a    = rs1_data;
    alu_b    = imm_i;
    wb_sel   = WbAlu;
    wb_en    = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OpReg: begin
        alu_op = {instr[30], funct3};
        alu_b  = rs2_data;
        wb_en  = 1'b1;
      end
      OpImm: begin
        // Only SRAI uses bit 30 as an opcode bit; elsewhere it is immediate.
        alu_op = {(funct3 == 3'b101) & instr[30], funct3};
        wb_en  = 1'b1;
      end
      OpLoad: begin
        wb_sel = WbLoad;
        wb_en  = 1'b1;
      end
      OpStore: begin
        alu_b    = imm_s;
        is_store = 1'b1;
      end
      OpAuipc: begin
        alu_a = pc_q;
        alu_b = imm_u;
        wb_en = 1'b1;
      end
      OpLui: begin
        wb_sel = WbImmU;
        wb_en  = 1'b1;
      end
      OpJal, OpJalr: begin
        wb_sel = WbPc4;
        wb_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset blocks all architectural writes, not just the PC.
  assign rf_we   = wb_en & rst;
  assign dmem_we = is_store & rst;

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_tgt = (rs1_data + imm_i) & ~32'd1;
  assign dmem_idx = alu_result[DmemAw+1:2];

  // Load path: byte/half lane select then sign or zero extension.
  always_comb begin
    dmem_rdata = dmem[dmem_idx];
    ld_byte    = dmem_rdata[{alu_result[1:0], 3'b000} +: 8];
    ld_half    = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Store path: replicate data across lanes and enable only the addressed bytes.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = rs2_data;
    case (funct3)
      3'b000: begin
        byte_en    = 4'b0001 << alu_result[1:0];
        store_data = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        byte_en    = alu_result[1] ? 4'b1100 : 4'b0011;
        store_data = {2{rs2_data[15:0]}};
      end
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Writeback mux.
  always_comb begin
    case (wb_sel)
      WbLoad:  rd_data = load_data;
      WbPc4:   rd_data = pc_plus4;
      WbImmU:  rd_data = imm_u;
      default: rd_data = alu_result;
    endcase
  end

  // Branch condition and next-PC select.
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  br_taken = !($signed(rs1_data) < $signed(rs2_data));
      3'b110:  br_taken = (rs1_data < rs2_data);
      3'b111:  br_taken = !(rs1_data < rs2_data);
      default: br_taken = 1'b0;
    endcase
    case (opcode)
      OpJal:    pc_d = pc_q + imm_j;
      OpJalr:   pc_d = jalr_tgt;
      OpBranch: pc_d = br_taken ? (pc_q + imm_b) : pc_plus4;
      default:  pc_d = pc_plus4;
    endcase
  end

  // Data memory byte-enable write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  // Program counter, the only reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: preloads program/registers hierarchically,
// steps the core and compares architectural state against hand-computed values.
module tb_rv32i_single_cycle_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv32i_single_cycle_core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Hold reset, fill imem with NOPs and clear the register file.
  task automatic begin_test();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.inst_mem_i.mem[i] = 32'h0000_0013;
    for (int i = 0; i < 32; i++) dut.reg_file_i.reg_mem[i] = 32'd0;
  endtask

  // One clock in reset, then release on the falling edge.
  task automatic release_rst();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;

    // Basic ADDI/ADD and reset behaviour.
    begin_test();
    dut.inst_mem_i.mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    dut.inst_mem_i.mem[1] = enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13);
    dut.inst_mem_i.mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    #1;
    check_eq("reset_pc", dut.pc_q, 32'h0);
    release_rst();
    step(5);
    check_eq("addi_x1", dut.reg_file_i.reg_mem[1], 32'd5);
    check_eq("addi_x2", dut.reg_file_i.reg_mem[2], 32'd7);
    check_eq("add_x3", dut.reg_file_i.reg_mem[3], 32'd12);
    check_eq("pc_after5", dut.pc_q, 32'h14);
    rst = 1'b0;
    #1;
    check_eq("async_rst_pc", dut.pc_q, 32'h0);
    check_eq("rst_keeps_x3", dut.reg_file_i.reg_mem[3], 32'd12);
    dut.reg_file_i.reg_mem[1] = 32'h55;
    step(2);
    check_eq("no_wr_in_rst", dut.reg_file_i.reg_mem[1], 32'h55);
    check_eq("pc_held_rst", dut.pc_q, 32'h0);

    // Loads and stores.
    begin_test();
    dut.reg_file_i.reg_mem[1] = 32'h10;
    dut.reg_file_i.reg_mem[2] = 32'hDEAD_BEEF;
    dut.inst_mem_i.mem[0] = enc_s(12'd0, 5'd2, 5'd1, 3'd2);
    dut.inst_mem_i.mem[1] = enc_i(12'd0, 5'd1, 3'd2, 5'd4, 7'h03);
    dut.inst_mem_i.mem[2] = enc_i(12'd0, 5'd1, 3'd0, 5'd8, 7'h03);
    dut.inst_mem_i.mem[3] = enc_i(12'd2, 5'd1, 3'd5, 5'd9, 7'h03);
    dut.inst_mem_i.mem[4] = enc_s(12'd1, 5'd1, 5'd1, 3'd0);
    dut.inst_mem_i.mem[5] = enc_i(12'd0, 5'd1, 3'd2, 5'd10, 7'h03);
    dut.inst_mem_i.mem[6] = enc_i(12'd2, 5'd1, 3'd1, 5'd11, 7'h03);
    dut.inst_mem_i.mem[7] = enc_i(12'd3, 5'd1, 3'd4, 5'd24, 7'h03);
    release_rst();
    step(8);
    check_eq("lw_x4", dut.reg_file_i.reg_mem[4], 32'hDEAD_BEEF);
    check_eq("lb_x8", dut.reg_file_i.reg_mem[8], 32'hFFFF_FFEF);
    check_eq("lhu_x9", dut.reg_file_i.reg_mem[9], 32'h0000_DEAD);
    check_eq("sb_dmem", dut.dmem[4], 32'hDEAD_10EF);
    check_eq("lw_x10", dut.reg_file_i.reg_mem[10], 32'hDEAD_10EF);
    check_eq("lh_x11", dut.reg_file_i.reg_mem[11], 32'hFFFF_DEAD);
    check_eq("lbu_x24", dut.reg_file_i.reg_mem[24], 32'h0000_00DE);

    // JAL / JALR.
    begin_test();
    dut.reg_file_i.reg_mem[12] = 32'hAA;
    dut.inst_mem_i.mem[3] = enc_j(32'd8, 5'd5);
    dut.inst_mem_i.mem[4] = enc_i(12'd1, 5'd0, 3'd0, 5'd12, 7'h13);
    dut.inst_mem_i.mem[5] = enc_i(12'd0, 5'd5, 3'd0, 5'd0, 7'h67);
    release_rst();
    step(3);
    check_eq("pc_at_jal", dut.pc_q, 32'h0C);
    step(1);
    check_eq("jal_link", dut.reg_file_i.reg_mem[5], 32'h10);
    check_eq("jal_target", dut.pc_q, 32'h14);
    check_eq("jal_skip", dut.reg_file_i.reg_mem[12], 32'hAA);
    step(1);
    check_eq("jalr_target", dut.pc_q, 32'h10);
    check_eq("jalr_x0", dut.reg_file_i.reg_mem[0], 32'h0);
    step(1);
    check_eq("after_jalr", dut.reg_file_i.reg_mem[12], 32'h1);

    // LUI / AUIPC.
    begin_test();
    dut.inst_mem_i.mem[6] = enc_u(20'h12345, 5'd6, 7'h37);
    dut.inst_mem_i.mem[7] = enc_u(20'h00001, 5'd7, 7'h17);
    release_rst();
    step(8);
    check_eq("lui_x6", dut.reg_file_i.reg_mem[6], 32'h1234_5000);
    check_eq("auipc_x7", dut.reg_file_i.reg_mem[7], 32'h0000_101C);
    check_eq("pc_u", dut.pc_q, 32'h20);

    // Branches and x0.
    begin_test();
    dut.reg_file_i.reg_mem[1] = 32'hFFFF_FFFF;
    dut.reg_file_i.reg_mem[2] = 32'h1;
    dut.inst_mem_i.mem[0] = enc_b(32'd8, 5'd2, 5'd1, 3'd4);
    dut.inst_mem_i.mem[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd13, 7'h13);
    dut.inst_mem_i.mem[2] = enc_b(32'd8, 5'd2, 5'd1, 3'd6);
    dut.inst_mem_i.mem[3] = enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);
    dut.inst_mem_i.mem[4] = enc_b(32'hFFFF_FFFC, 5'd1, 5'd1, 3'd0);
    release_rst();
    step(1);
    check_eq("blt_taken", dut.pc_q, 32'h08);
    step(1);
    check_eq("bltu_not_taken", dut.pc_q, 32'h0C);
    step(1);
    check_eq("x0_stays_0", dut.reg_file_i.reg_mem[0], 32'h0);
    step(1);
    check_eq("beq_back", dut.pc_q, 32'h0C);
    check_eq("blt_skipped", dut.reg_file_i.reg_mem[13], 32'h0);

    // ALU corner cases and unknown opcode.
    begin_test();
    dut.reg_file_i.reg_mem[2]  = 32'h1;
    dut.reg_file_i.reg_mem[14] = 32'h8000_0000;
    dut.reg_file_i.reg_mem[15] = 32'd4;
    dut.reg_file_i.reg_mem[22] = 32'd33;
    dut.reg_file_i.reg_mem[31] = 32'h1234;
    dut.inst_mem_i.mem[0]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
    dut.inst_mem_i.mem[1]  = enc_r(7'h20, 5'd15, 5'd14, 3'd5, 5'd16);
    dut.inst_mem_i.mem[2]  = enc_r(7'h00, 5'd15, 5'd14, 3'd5, 5'd17);
    dut.inst_mem_i.mem[3]  = enc_i(12'h404, 5'd14, 3'd5, 5'd18, 7'h13);
    dut.inst_mem_i.mem[4]  = enc_r(7'h00, 5'd2, 5'd3, 3'd2, 5'd19);
    dut.inst_mem_i.mem[5]  = enc_r(7'h00, 5'd2, 5'd3, 3'd3, 5'd20);
    dut.inst_mem_i.mem[6]  = enc_r(7'h00, 5'd22, 5'd2, 3'd1, 5'd21);
    dut.inst_mem_i.mem[7]  = enc_i(12'hFFF, 5'd14, 3'd4, 5'd23, 7'h13);
    dut.inst_mem_i.mem[8]  = 32'hFFFF_FFFF;
    dut.inst_mem_i.mem[9]  = enc_i(12'd1, 5'd1, 3'd3, 5'd24, 7'h13);
    dut.inst_mem_i.mem[10] = enc_i(12'd1, 5'd3, 3'd0, 5'd25, 7'h13);
    dut.reg_file_i.reg_mem[20] = 32'h77;
    release_rst();
    step(11);
    check_eq("sub_wrap", dut.reg_file_i.reg_mem[3], 32'hFFFF_FFFF);
    check_eq("sra", dut.reg_file_i.reg_mem[16], 32'hF800_0000);
    check_eq("srl", dut.reg_file_i.reg_mem[17], 32'h0800_0000);
    check_eq("srai", dut.reg_file_i.reg_mem[18], 32'hF800_0000);
    check_eq("slt", dut.reg_file_i.reg_mem[19], 32'h1);
    check_eq("sltu", dut.reg_file_i.reg_mem[20], 32'h0);
    check_eq("sll_mod32", dut.reg_file_i.reg_mem[21], 32'h2);
    check_eq("xori", dut.reg_file_i.reg_mem[23], 32'h7FFF_FFFF);
    check_eq("unknown_nop", dut.reg_file_i.reg_mem[31], 32'h1234);
    check_eq("sltiu", dut.reg_file_i.reg_mem[24], 32'h1);
    check_eq("addi_wrap", dut.reg_file_i.reg_mem[25], 32'h0);
    check_eq("pc_alu", dut.pc_q, 32'h2C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
